// File: rtl/apb_soc_demux.sv
// APB 1-to-N demultiplexer. An address-rule decoder picks one downstream slave, and a
// registered four-state FSM (IDLE/SETUP/ACCESS/RESP) replays the transfer on that port.
// A per-transfer timeout aborts transfers to slaves that never raise pready.
module apb_soc_demux #(
    parameter int unsigned NUM_SLAVES     = 11,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    // Rule i occupies bits [i*96 +: 96] as {idx, start_addr, end_addr}
    input  logic [NUM_SLAVES*96-1:0] addr_map_i,
    // Upstream request
    input  logic [31:0]              paddr_i,
    input  logic [31:0]              pwdata_i,
    input  logic [3:0]               pstrb_i,
    input  logic                     pwrite_i,
    input  logic                     psel_i,
    input  logic                     penable_i,
    // Upstream response
    output logic [31:0]              prdata_o,
    output logic                     pready_o,
    output logic                     pslverr_o,
    // Downstream request
    output logic [NUM_SLAVES-1:0]    psel_o,
    output logic                     penable_o,
    output logic [31:0]              paddr_o,
    output logic [31:0]              pwdata_o,
    output logic [3:0]               pstrb_o,
    output logic                     pwrite_o,
    // Downstream responses
    input  logic [NUM_SLAVES*32-1:0] prdata_i,
    input  logic [NUM_SLAVES-1:0]    pready_i,
    input  logic [NUM_SLAVES-1:0]    pslverr_i,
    output logic                     timeout_o
);

    localparam int unsigned PortW  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [15:0] CntMax = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e             state_q, state_d;
    logic [PortW-1:0]   port_q, port_d;
    logic [31:0]        paddr_q, paddr_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic [3:0]         pstrb_q, pstrb_d;
    logic               pwrite_q, pwrite_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               slverr_q, slverr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    // Set when the master abandoned the transfer; its response is then swallowed
    logic               drop_q, drop_d;

    logic               dec_found;
    logic [31:0]        dec_idx;
    logic               dec_hit;

    logic               sel_ready;
    logic               sel_err;
    logic [31:0]        sel_rdata;

    // Address decode: first (lowest-index) matching rule wins, end address exclusive
    always_comb begin
        dec_found = 1'b0;
        dec_idx   = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!dec_found &&
                (paddr_i >= addr_map_i[i*96+32 +: 32]) &&
                (paddr_i <  addr_map_i[i*96    +: 32])) begin
                dec_found = 1'b1;
                dec_idx   = addr_map_i[i*96+64 +: 32];
            end
        end
        dec_hit = dec_found && (dec_idx < NUM_SLAVES);
    end

    // Mux the response of the currently addressed slave; all other ports are ignored
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (port_q == PortW'(i)) begin
                sel_ready = pready_i[i];
                sel_err   = pslverr_i[i];
                sel_rdata = prdata_i[i*32 +: 32];
            end
        end
    end

    // Next-state logic for the transfer FSM and its datapath registers
    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pwrite_d  = pwrite_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        drop_d    = drop_q;

        unique case (state_q)
            StIdle: begin
                if (psel_i && !penable_i) begin
                    paddr_d  = paddr_i;
                    pwdata_d = pwdata_i;
                    pstrb_d  = pstrb_i;
                    pwrite_d = pwrite_i;
                    drop_d   = 1'b0;
                    cnt_d    = '0;
                    if (dec_hit) begin
                        port_d  = dec_idx[PortW-1:0];
                        state_d = StSetup;
                    end else begin
                        // Decode miss answers straight away with an error
                        rdata_d  = '0;
                        slverr_d = 1'b1;
                        state_d  = StResp;
                    end
                end
            end
            StSetup: begin
                if (!psel_i) begin
                    drop_d = 1'b1;
                end
                state_d = StAccess;
            end
            StAccess: begin
                if (!psel_i) begin
                    drop_d = 1'b1;
                end
                if (sel_ready) begin
                    rdata_d  = sel_rdata;
                    slverr_d = sel_err;
                    state_d  = StResp;
                end else if (cnt_q == CntMax) begin
                    rdata_d   = '0;
                    slverr_d  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            port_q    <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pwrite_q  <= 1'b0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pwrite_q  <= pwrite_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
        end
    end

    // Downstream select decoded from registered state only, so reset clears it at once
    always_comb begin
        psel_o = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if ((state_q == StSetup || state_q == StAccess) && (port_q == PortW'(i))) begin
                psel_o[i] = 1'b1;
            end
        end
        penable_o = (state_q == StAccess);
    end

    // Upstream response is only visible in RESP during the master's access phase
    always_comb begin
        pready_o  = (state_q == StResp) && psel_i && penable_i && !drop_q;
        prdata_o  = pready_o ? rdata_q : 32'h0;
        pslverr_o = pready_o ? slverr_q : 1'b0;
    end

    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pstrb_o   = pstrb_q;
    assign pwrite_o  = pwrite_q;
    assign timeout_o = timeout_q;

endmodule

// File: doc/apb_soc_demux.md
APB_SOC_DEMUX -- requirements
Module: apb_soc_demux

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 11, the number of downstream APB slave ports.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum number of ACCESS cycles before a transfer is aborted (legal range 2..65535).
REQ-003 SHALL have port clk_i  input  1  clock; the block has one clock and all logic is on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addr_map_i  input  NUM_SLAVES x 96  rule array; each rule is {idx[31:0], start_addr[31:0], end_addr[31:0]}.
REQ-006 SHALL have ports paddr_i 32, pwdata_i 32, pstrb_i 4, pwrite_i 1, psel_i 1, penable_i 1 (all inputs): the upstream APB request.
REQ-007 SHALL have ports prdata_o 32, pready_o 1, pslverr_o 1 (all outputs): the upstream APB response.
REQ-008 SHALL have ports psel_o NUM_SLAVES, penable_o 1, paddr_o 32, pwdata_o 32, pstrb_o 4, pwrite_o 1 (all outputs): the registered downstream request.
REQ-009 SHALL have ports prdata_i NUM_SLAVES x 32, pready_i NUM_SLAVES, pslverr_i NUM_SLAVES (all inputs): the downstream responses.
REQ-010 SHALL have port timeout_o  output  1  one-cycle pulse raised when a transfer is aborted on timeout.

Function
REQ-011 A rule SHALL match when start_addr <= paddr_i < end_addr (unsigned, end exclusive); if several rules match, the lowest rule index SHALL win.
REQ-012 The winning rule's idx field SHALL select the downstream port; an idx >= NUM_SLAVES, or no match at all, SHALL be a decode miss.
REQ-013 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP.
REQ-014 In IDLE, on psel_i & ~penable_i, the block SHALL register paddr/pwdata/pstrb/pwrite and the decoded port, then move to SETUP on a hit or to RESP on a miss.
REQ-015 In SETUP, only psel_o[port] SHALL be 1 and penable_o SHALL be 0; the FSM SHALL move to ACCESS unconditionally.
REQ-016 In ACCESS, psel_o[port] and penable_o SHALL be 1 and the timeout counter SHALL increment each cycle.
REQ-017 In ACCESS, pready_i[port]=1 SHALL capture prdata_i[port] and pslverr_i[port] into response registers and move the FSM to RESP.
REQ-018 When the counter reaches TIMEOUT_CYCLES-1 with pready_i[port] still 0, the block SHALL: drop psel_o/penable_o next cycle, go to RESP with pslverr=1 and prdata=0, and pulse timeout_o for 1 cycle.
REQ-019 A decode miss SHALL respond with pslverr=1 and prdata=0, and SHALL NOT assert any psel_o bit.
REQ-020 pready_o SHALL be 1 only in RESP and only while psel_i & penable_i; prdata_o and pslverr_o SHALL be the response registers while pready_o=1 and 0 otherwise.
REQ-021 RESP SHALL last exactly one cycle and then return to IDLE; back-to-back transfers SHALL therefore be separated by at least one IDLE cycle.
REQ-022 Hit latency: upstream setup at cycle 0, downstream setup at cycle 1, downstream access at cycle 2; if pready_i is 1 at cycle 2, pready_o SHALL be 1 at cycle 3.
REQ-023 Miss latency: pready_o SHALL be 1 at cycle 1, i.e. in the upstream access phase.
REQ-024 If psel_i drops before RESP (protocol violation), the downstream transfer SHALL still complete or time out, the response SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-025 pready_i and pslverr_i of unselected ports SHALL be ignored.
REQ-026 pwrite_o, paddr_o, pwdata_o and pstrb_o SHALL stay stable from SETUP through the end of ACCESS.
REQ-027 The counter SHALL be 16 bits wide, cleared on entry to SETUP, and SHALL never wrap within a transfer.

Reset
REQ-028 While rst_ni=0, the FSM SHALL be IDLE, the counter 0, and psel_o, penable_o, paddr_o, pwdata_o, pstrb_o, pwrite_o, prdata_o, pready_o, pslverr_o and timeout_o all 0.
REQ-029 Reset asserted mid-transfer SHALL drop psel_o and penable_o immediately (asynchronously), and no response SHALL be issued after release.
REQ-030 After rst_ni rises, the block SHALL accept a new upstream setup on the first clock edge.

Verification
REQ-031 Read hit: paddr_i=0x1A10_5004 with the GPIO rule (idx 4, 0x1A10_5000..0x1A10_6000); slave 4 gives pready_i at cycle 2 with prdata 0xCAFE_0001 -> psel_o=0x010, and pready_o=1 at cycle 3 with prdata_o=0xCAFE_0001 and pslverr_o=0.
REQ-032 Write to UDMA end boundary: paddr_i=0x1A22_1FFC hits the UDMA rule, while paddr_i=0x1A22_2000 hits the APBUART rule -> the correct single psel_o bit is set and pwdata_o/pstrb_o are forwarded unchanged.
REQ-033 Decode miss: paddr_i=0x1A10_2000 (gap in the map) -> pready_o=1 and pslverr_o=1 at cycle 1, prdata_o=0, and psel_o stays 0.
REQ-034 Timeout: the slave holds pready_i=0 with TIMEOUT_CYCLES=8 -> after 8 ACCESS cycles timeout_o pulses once, pslverr_o=1 and psel_o=0; the next transfer succeeds.
REQ-035 Slave error plus overlap: two rules both cover 0x1A10_8000 and the lower-index rule selects port 7, which returns pslverr_i=1 -> only port 7 is selected and pslverr_o=1.
REQ-036 Reset mid-ACCESS: rst_ni pulled low during ACCESS -> all outputs are 0 immediately, and after release there is no pready_o until a new request arrives.
